// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the multi-channel programmable delay timer.
package prog_delay_pkg;

    typedef enum logic [1:0] {
        ONESHOT  = 2'd0,
        PERIODIC = 2'd1,
        RETRIG   = 2'd2,
        RSVD     = 2'd3
    } tmr_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_e;

    // A programmed delay of zero behaves as a single tick.
    function automatic logic [31:0] eff_delay(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/delay_timer_channel.sv
// One timer channel: shadow/active config, prescaler, down-counter and IDLE/RUN FSM.
//   state | meaning
//   IDLE  | waiting for trig; shadow config may be rewritten freely
//   RUN   | counting ticks; expiry at prescaler==0 with count==1
module delay_timer_channel
    import prog_delay_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic [1:0]         cfg_mode,
    input  logic               trig,
    input  logic               abort,
    output logic               busy,
    output logic               expired,
    output logic               out_level
);

    tmr_state_e         state_q, state_d;
    tmr_mode_e          sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [CNT_W-1:0]   sh_delay_q, sh_delay_d, cnt_q, cnt_d;
    logic [PRESC_W-1:0] sh_presc_q, sh_presc_d, act_presc_q, act_presc_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               level_q, level_d;
    logic               load;

    always_comb begin
        state_d     = state_q;
        sh_mode_d   = sh_mode_q;
        sh_delay_d  = sh_delay_q;
        sh_presc_d  = sh_presc_q;
        act_mode_d  = act_mode_q;
        act_presc_d = act_presc_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        level_d     = level_q;
        load        = 1'b0;
        expired     = 1'b0;

        if (cfg_we) begin
            sh_delay_d = cfg_delay;
            sh_presc_d = cfg_presc;
            sh_mode_d  = tmr_mode_e'(cfg_mode);
        end

        // abort outranks both a retrigger and an expiry landing in the same cycle
        case (state_q)
            IDLE: begin
                if (trig && !abort) load = 1'b1;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (trig && act_mode_q == RETRIG) begin
                    load = 1'b1;
                end else if (presc_q == '0 && cnt_q == CNT_W'(1)) begin
                    expired = 1'b1;
                    level_d = !level_q;
                    if (act_mode_q == PERIODIC) load = 1'b1;
                    else                        state_d = IDLE;
                end else if (presc_q == '0) begin
                    presc_d = act_presc_q;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    presc_d = presc_q - PRESC_W'(1);
                end
            end
        endcase

        // a load always samples the shadow as it stood before this cycle's write
        if (load) begin
            state_d     = RUN;
            cnt_d       = CNT_W'(eff_delay(32'(sh_delay_q)));
            presc_d     = sh_presc_q;
            act_presc_d = sh_presc_q;
            act_mode_d  = sh_mode_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_mode_q   <= ONESHOT;
            sh_delay_q  <= '0;
            sh_presc_q  <= '0;
            act_mode_q  <= ONESHOT;
            act_presc_q <= '0;
            cnt_q       <= '0;
            presc_q     <= '0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_mode_q   <= sh_mode_d;
            sh_delay_q  <= sh_delay_d;
            sh_presc_q  <= sh_presc_d;
            act_mode_q  <= act_mode_d;
            act_presc_q <= act_presc_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            level_q     <= level_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign out_level = level_q;

endmodule

// File: rtl/prog_delay_timer_mc.sv
// Multi-channel programmable delay timer: config channel decode plus NUM_CH independent channels.
module prog_delay_timer_mc
    import prog_delay_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic [1:0]         cfg_mode,
    input  logic [NUM_CH-1:0]  trig,
    input  logic [NUM_CH-1:0]  abort,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  expired,
    output logic [NUM_CH-1:0]  out_level
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;

        // channel numbers beyond NUM_CH-1 match no instance and are dropped
        assign ch_we = cfg_we && (32'(cfg_ch) == i);

        delay_timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .cfg_we    (ch_we),
            .cfg_delay (cfg_delay),
            .cfg_presc (cfg_presc),
            .cfg_mode  (cfg_mode),
            .trig      (trig[i]),
            .abort     (abort[i]),
            .busy      (busy[i]),
            .expired   (expired[i]),
            .out_level (out_level[i])
        );
    end

endmodule

// File: tb/tb_prog_delay_timer_mc.sv
// Bench for prog_delay_timer_mc: directed scenarios with fixed expectations plus random traffic vs a deadline model.
module tb_prog_delay_timer_mc;

    logic        clk = 1'b0;
    logic        reset, cfg_we;
    logic [1:0]  cfg_ch, cfg_mode;
    logic [15:0] cfg_delay;
    logic [7:0]  cfg_presc;
    logic [3:0]  trig, abort, busy, expired, out_level;
    logic [3:0]  eb, ee, el;

    int          n_cmp = 0;
    int          n_err = 0;
    longint      cyc = 0;

    // model: each running channel knows the absolute cycle of its next expiry
    bit          m_run [4];
    bit          m_lvl [4];
    longint      m_due [4];
    int          m_am [4], m_sd [4], m_sp [4], m_sm [4];

    prog_delay_timer_mc dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_delay(cfg_delay), .cfg_presc(cfg_presc), .cfg_mode(cfg_mode),
        .trig(trig), .abort(abort), .busy(busy), .expired(expired), .out_level(out_level)
    );

    always #5 clk = ~clk;

    function automatic longint span(int d, int p);
        return longint'((d == 0) ? 1 : d) * longint'(p + 1);
    endfunction

    task automatic model_update();
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_run[i] = 0; m_lvl[i] = 0; m_due[i] = 0;
                m_am[i] = 0; m_sd[i] = 0; m_sp[i] = 0; m_sm[i] = 0;
            end else begin
                if (!m_run[i]) begin
                    if (trig[i] && !abort[i]) begin
                        m_run[i] = 1; m_due[i] = cyc + span(m_sd[i], m_sp[i]); m_am[i] = m_sm[i];
                    end
                end else if (abort[i]) begin
                    m_run[i] = 0;
                end else if (trig[i] && m_am[i] == 2) begin
                    m_due[i] = cyc + span(m_sd[i], m_sp[i]); m_am[i] = m_sm[i];
                end else if (cyc == m_due[i]) begin
                    m_lvl[i] = !m_lvl[i];
                    if (m_am[i] == 1) begin
                        m_due[i] = cyc + span(m_sd[i], m_sp[i]); m_am[i] = m_sm[i];
                    end else begin
                        m_run[i] = 0;
                    end
                end
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_sd[i] = int'(cfg_delay); m_sp[i] = int'(cfg_presc); m_sm[i] = int'(cfg_mode);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_we = 1'b0; trig = '0; abort = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int d, input int p, input int m);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_delay = 16'(d); cfg_presc = 8'(p); cfg_mode = 2'(m);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; trig = 4'hF; abort = '0; cfg_we = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, expired, out_level} !== 12'h000) begin
                n_err++;
                $display("FAIL reset t=%0d busy/exp/lvl got %b/%b/%b want 0000/0000/0000", t, busy, expired, out_level);
            end
            step();
        end
        reset = 1'b0; trig = '0;
    endtask

    task automatic test_oneshot();
        do_reset(); cfg_write(0, 4, 0, 0);
        for (int t = 0; t <= 20; t++) begin
            trig = (t == 10) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            eb = {3'b0, t >= 11 && t <= 14}; ee = {3'b0, t == 14}; el = {3'b0, t >= 15};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL oneshot t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0;
    endtask

    task automatic test_periodic_abort();
        do_reset(); cfg_write(1, 3, 1, 1);
        for (int t = 0; t <= 30; t++) begin
            trig  = (t == 0)  ? 4'b0010 : 4'b0000;
            abort = (t == 20) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            eb = {2'b0, t >= 1 && t <= 20, 1'b0};
            ee = {2'b0, t == 6 || t == 12 || t == 18, 1'b0};
            el = {2'b0, (t >= 7 && t <= 12) || t >= 19, 1'b0};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL periodic t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0; abort = '0;
    endtask

    task automatic test_retrig();
        do_reset(); cfg_write(2, 5, 0, 2); cfg_write(0, 5, 0, 0);
        for (int t = 0; t <= 12; t++) begin
            trig = (t == 0 || t == 3) ? 4'b0101 : 4'b0000;
            @(negedge clk);
            eb = {1'b0, t >= 1 && t <= 8, 1'b0, t >= 1 && t <= 5};
            ee = {1'b0, t == 8, 1'b0, t == 5};
            el = {1'b0, t >= 9, 1'b0, t >= 6};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL retrig t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0;
    endtask

    task automatic test_cfg_while_busy();
        do_reset(); cfg_write(3, 10, 0, 0);
        for (int t = 0; t <= 20; t++) begin
            trig = (t == 0 || t == 15) ? 4'b1000 : 4'b0000;
            cfg_we = (t == 4); cfg_ch = 2'd3; cfg_delay = 16'd2; cfg_presc = 8'd0; cfg_mode = 2'd0;
            @(negedge clk);
            eb = {(t >= 1 && t <= 10) || (t >= 16 && t <= 17), 3'b0};
            ee = {t == 10 || t == 17, 3'b0};
            el = {t >= 11 && t <= 17, 3'b0};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL cfg_busy t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0; cfg_we = 1'b0;
    endtask

    task automatic test_abort_reset();
        do_reset(); cfg_write(0, 4, 0, 0); cfg_write(1, 20, 0, 1); cfg_write(2, 1, 0, 0);
        for (int t = 0; t <= 18; t++) begin
            trig  = {1'b0, t == 0, t == 2 || t == 14, t == 0};
            abort = (t == 4) ? 4'b0001 : 4'b0000;
            reset = (t == 12);
            @(negedge clk);
            eb = {1'b0, t == 1, (t >= 3 && t <= 12) || t == 15, t >= 1 && t <= 4};
            ee = {1'b0, t == 1, t == 15, 1'b0};
            el = {1'b0, t >= 2 && t <= 12, t >= 16, 1'b0};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL abort_reset t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0; abort = '0; reset = 1'b0;
    endtask

    task automatic test_all_channels();
        do_reset();
        for (int c = 0; c < 4; c++) cfg_write(c, c, 0, 0);
        for (int t = 0; t <= 8; t++) begin
            trig = (t == 2) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            eb = {t >= 3 && t <= 5, t >= 3 && t <= 4, t == 3, t == 3};
            ee = {t == 5, t == 4, t == 3, t == 3};
            el = {t >= 6, t >= 5, t >= 4, t >= 4};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL all_ch t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0;
    endtask

    task automatic test_back_to_back();
        do_reset(); cfg_write(0, 2, 0, 0);
        for (int t = 0; t <= 12; t++) begin
            trig = (t <= 9) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            eb = {3'b0, t >= 1 && (t % 3) != 0};
            ee = {3'b0, (t % 3) == 2};
            el = {3'b0, ((t / 3) % 2) == 1};
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL back_to_back t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 800; t++) begin
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_delay = 16'($urandom_range(0, 6));
            cfg_presc = 8'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                trig[i]  = ($urandom_range(0, 5) == 0);
                abort[i] = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                eb[i] = m_run[i];
                ee[i] = m_run[i] && !abort[i] && !(trig[i] && m_am[i] == 2) && (cyc == m_due[i]);
                el[i] = m_lvl[i];
            end
            n_cmp++;
            if ({busy, expired, out_level} !== {eb, ee, el}) begin
                n_err++;
                $display("FAIL random t=%0d busy/exp/lvl got %b/%b/%b want %b/%b/%b", t, busy, expired, out_level, eb, ee, el);
            end
            step();
        end
        trig = '0; abort = '0; cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_presc = '0;
        cfg_mode = '0; trig = '0; abort = '0;
        #1;
        test_reset();
        test_oneshot();
        test_periodic_abort();
        test_retrig();
        test_cfg_while_busy();
        test_abort_reset();
        test_all_channels();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
